deserializer: RTL

- Receive-side counterpart of the serial byte transmitter. Recovers bytes from a one-bit-per-clock, MSB-first serial stream.
- In stuffed mode:
  - removes stuffed zeros (a 0 inserted after five consecutive 1s);
  - detects HDLC-style flags (01111110) for byte alignment;
  - detects aborts (7 or more consecutive 1s).
- Delivers each recovered byte with a one-cycle strobe to the packet/framing logic.

---
 rtl/deserializer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/deserializer.sv
// MSB-first serial-to-byte receiver with optional HDLC destuffing, flag alignment
// and abort detection. Define DESER_FCS_EN to add the CRC-16 frame check (fcs_ok).
module deserializer (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_in,
    input  logic       use_stuffing,
    output logic [7:0] data_out,
    output logic       strobe,
    output logic       in_sync,
    output logic       flag,
    output logic       abort,
    output logic       frame_err
`ifdef DESER_FCS_EN
    ,
    output logic       fcs_ok
`endif
);

    typedef enum logic {HUNT, SYNCED} sync_t;

    sync_t      state_q, state_d;
    logic [2:0] ones_q, ones_d;
    logic [2:0] cnt_q, cnt_d;
    logic [6:0] part_q, part_d;
    logic [7:0] byte_d, dout_d;
    logic       strobe_d, flag_d, abort_d, ferr_d, take;

    assign in_sync = (state_q == SYNCED);

    always_comb begin
        ones_d   = data_in ? ((ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1) : 3'd0;
        state_d  = state_q;
        cnt_d    = cnt_q;
        part_d   = part_q;
        dout_d   = data_out;
        byte_d   = {part_q, data_in};
        strobe_d = 1'b0;
        flag_d   = 1'b0;
        abort_d  = 1'b0;
        ferr_d   = 1'b0;
        take     = 1'b0;
        if (!use_stuffing) begin
            state_d = SYNCED;
            take    = 1'b1;
        end else if (!data_in && ones_q == 3'd5) begin
            take = 1'b0;
        end else if (!data_in && ones_q == 3'd6) begin
            // an aligned closing flag leaves exactly 7 of its bits in the counter
            flag_d  = 1'b1;
            ferr_d  = (state_q == SYNCED) && (cnt_q != 3'd7);
            state_d = SYNCED;
            cnt_d   = 3'd0;
            part_d  = 7'd0;
        end else if (data_in && ones_q == 3'd6) begin
            abort_d = (state_q == SYNCED);
            state_d = HUNT;
            cnt_d   = 3'd0;
            part_d  = 7'd0;
        end else begin
            take = (state_q == SYNCED);
        end
        if (take) begin
            part_d = byte_d[6:0];
            if (cnt_q == 3'd7) begin
                dout_d   = byte_d;
                strobe_d = 1'b1;
                cnt_d    = 3'd0;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= HUNT;
            ones_q    <= 3'd0;
            cnt_q     <= 3'd0;
            part_q    <= 7'd0;
            data_out  <= 8'h00;
            strobe    <= 1'b0;
            flag      <= 1'b0;
            abort     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            ones_q    <= ones_d;
            cnt_q     <= cnt_d;
            part_q    <= part_d;
            data_out  <= dout_d;
            strobe    <= strobe_d;
            flag      <= flag_d;
            abort     <= abort_d;
            frame_err <= ferr_d;
        end
    end

`ifdef DESER_FCS_EN
    logic [15:0] crc_q, crc_d;
    logic        fcs_d;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
        end
        return r;
    endfunction

    // the received FCS is folded in too, so a good frame leaves a zero residue
    always_comb begin
        crc_d = crc_q;
        fcs_d = 1'b0;
        if (strobe_d) begin
            crc_d = crc_step(crc_q, dout_d);
        end
        if (flag_d) begin
            fcs_d = in_sync && (crc_q == 16'h0000);
            crc_d = 16'hFFFF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q  <= 16'hFFFF;
            fcs_ok <= 1'b0;
        end else begin
            crc_q  <= crc_d;
            fcs_ok <= fcs_d;
        end
    end
`endif

endmodule
